usehint_stream: RTL and testbench

Parametrised successor to the Dilithium UseHint stage in the verify datapath. Receives the packed hint vector h from the signature unpacker over a W-bit valid/ready stream and expands it into a K×256 hint bitmap. When `USEHINT_CHECK_EN` is defined, it also rejects malformed hints per FIPS 204. It then streams LANES coefficient pairs (r0, r1) per beat, producing corrected w1' coefficients for the w1 packer/SHAKE absorb.

---
 rtl/usehint_stream.sv | 218 +++++++++++++++++++++
 tb/tb_usehint_stream.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usehint_stream.sv
// usehint_stream: Dilithium UseHint stage for the verify datapath.
// Receives the packed hint vector h over a W-bit stream and expands it into a K x 256 bitmap.
// It then corrects LANES (r0, r1) coefficient pairs per beat into w1' values.
// Optional build macro USEHINT_CHECK_EN turns on malformed-hint rejection during EXPAND.
// Without the macro, hint_err is tied low.

module usehint_stream #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned COEFF_W = 24,
    parameter int unsigned W       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               sec_lvl,
    input  logic [W-1:0]             di,
    input  logic                     valid_i,
    output logic                     ready_i,
    input  logic [LANES*COEFF_W-1:0] poly0_i,
    input  logic [LANES*COEFF_W-1:0] poly1_i,
    input  logic                     poly_valid_i,
    output logic                     poly_ready_i,
    output logic [LANES*COEFF_W-1:0] poly_o,
    output logic                     poly_valid_o,
    input  logic                     poly_ready_o,
    output logic                     done,
    output logic                     hint_err
);
    localparam int BPB  = int'(W / 8);
    localparam int MAXB = 88;  // largest N (84) plus slack so count reads never leave the array

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RECV   = 3'd1;
    localparam logic [2:0] S_EXPAND = 3'd2;
    localparam logic [2:0] S_APPLY  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    lvl_q;
    logic [11:0]   cnt_q;
    logic [7:0]    buf_q [MAXB];
    logic [2047:0] bmp_q;

    logic [3:0]         k_num;
    logic [6:0]         omega;
    logic [7:0]         n_len;
    logic [COEFF_W-1:0] gamma2;
    logic [5:0]         m_val;
    logic [11:0]        n_beats;

    logic [6:0] p;
    logic [7:0] idx_byte;
    logic [7:0] c_raw [8];
    logic [7:0] c_sat [8];
    logic       used;
    logic [2:0] hk;
    logic       chk_fail;
    logic       recv_last, apply_hs, apply_last;

    // Per-level constants.
    always_comb begin
        case (lvl_q)
            2'd0: begin
                k_num = 4'd4; omega = 7'd80; gamma2 = COEFF_W'(95232); m_val = 6'd44;
            end
            2'd1: begin
                k_num = 4'd6; omega = 7'd55; gamma2 = COEFF_W'(261888); m_val = 6'd16;
            end
            default: begin
                k_num = 4'd8; omega = 7'd75; gamma2 = COEFF_W'(261888); m_val = 6'd16;
            end
        endcase
        n_len   = {1'b0, omega} + {4'b0, k_num};
        n_beats = 12'(k_num) * 12'(256 / LANES);
    end

    assign p          = cnt_q[6:0];
    assign idx_byte   = (p < 7'(MAXB)) ? buf_q[p] : 8'd0;
    assign recv_last  = (cnt_q + 12'(BPB)) >= {4'b0, n_len};
    assign apply_hs   = (state_q == S_APPLY) && poly_valid_i && poly_ready_o;
    assign apply_last = (cnt_q == n_beats - 12'd1);

    // Locate the poly owning index position p: smallest k with p < c[k] (counts saturate at omega).
    always_comb begin
        used = 1'b0;
        hk   = '0;
        for (int k = 0; k < 8; k++) begin
            c_raw[k] = buf_q[7'(omega + 7'(k))];
            c_sat[k] = (c_raw[k] > {1'b0, omega}) ? {1'b0, omega} : c_raw[k];
        end
        for (int k = 7; k >= 0; k--) begin
            if ((4'(k) < k_num) && ({1'b0, p} < c_sat[k])) begin
                used = 1'b1;
                hk   = 3'(k);
            end
        end
    end

`ifdef USEHINT_CHECK_EN
    logic       err_q;
    logic       prev_vld_q;
    logic [2:0] prev_k_q;
    logic [7:0] prev_idx_q;

    // Malformed-hint detection for the current EXPAND position.
    always_comb begin
        chk_fail = 1'b0;
        for (int k = 1; k < 8; k++) begin
            if ((4'(k) < k_num) && (c_raw[k] < c_raw[k-1])) chk_fail = 1'b1;
        end
        if (c_raw[3'(k_num - 4'd1)] > {1'b0, omega}) chk_fail = 1'b1;
        if (used && prev_vld_q && (prev_k_q == hk) && (idx_byte <= prev_idx_q)) chk_fail = 1'b1;
        if (!used && (idx_byte != 8'd0)) chk_fail = 1'b1;
    end

    // Remember the last used index for the ordering check; latch the first failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            prev_vld_q <= 1'b0;
            prev_k_q   <= '0;
            prev_idx_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            err_q      <= 1'b0;
            prev_vld_q <= 1'b0;
        end else if (state_q == S_EXPAND) begin
            if (chk_fail) err_q <= 1'b1;
            if (used) begin
                prev_vld_q <= 1'b1;
                prev_k_q   <= hk;
                prev_idx_q <= idx_byte;
            end
        end
    end

    assign hint_err = err_q;
`else
    assign chk_fail = 1'b0;
    assign hint_err = 1'b0;
`endif

    // Job sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RECV;
            S_RECV:   if (valid_i && recv_last) state_d = S_EXPAND;
            S_EXPAND: begin
                if (chk_fail) state_d = S_DONE;
                else if (p == omega - 7'd1) state_d = S_APPLY;
            end
            S_APPLY:  if (apply_hs && apply_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, shared position counter, byte buffer and hint bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lvl_q   <= 2'd0;
            cnt_q   <= '0;
            bmp_q   <= '0;
            for (int i = 0; i < MAXB; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    lvl_q <= (sec_lvl == 3'd2) ? 2'd0 : (sec_lvl == 3'd3) ? 2'd1 : 2'd2;
                    cnt_q <= '0;
                    bmp_q <= '0;
                    for (int i = 0; i < MAXB; i++) buf_q[i] <= '0;
                end
                S_RECV: if (valid_i) begin
                    for (int j = 0; j < BPB; j++) begin
                        if ((cnt_q + 12'(j)) < {4'b0, n_len}) buf_q[7'(cnt_q + 12'(j))] <= di[8*j +: 8];
                    end
                    cnt_q <= recv_last ? 12'd0 : cnt_q + 12'(BPB);
                end
                S_EXPAND: begin
                    if (used) bmp_q[{hk, idx_byte}] <= 1'b1;
                    cnt_q <= (state_d == S_EXPAND) ? cnt_q + 12'd1 : 12'd0;
                end
                S_APPLY: if (apply_hs) cnt_q <= cnt_q + 12'd1;
                default: ;
            endcase
        end
    end

    assign ready_i      = (state_q == S_RECV);
    assign poly_ready_i = (state_q == S_APPLY) && poly_ready_o;
    assign poly_valid_o = (state_q == S_APPLY) && poly_valid_i;
    assign done         = (state_q == S_DONE);

    // Per-lane correction; combinational so APPLY adds no latency.
    always_comb begin
        logic [10:0]        gidx;
        logic [COEFF_W-1:0] r0, r1, res;
        poly_o = '0;
        gidx   = '0;
        r0     = '0;
        r1     = '0;
        res    = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            gidx = 11'(cnt_q * 12'(LANES) + 12'(l));
            r0   = poly0_i[l*COEFF_W +: COEFF_W];
            r1   = poly1_i[l*COEFF_W +: COEFF_W];
            if (!bmp_q[gidx]) res = r1;
            else if ((r0 != '0) && (r0 <= gamma2))
                res = (r1 == COEFF_W'(m_val - 6'd1)) ? '0 : r1 + 1'b1;
            else
                res = (r1 == '0) ? COEFF_W'(m_val - 6'd1) : r1 - 1'b1;
            if (state_q == S_APPLY) poly_o[l*COEFF_W +: COEFF_W] = res;
        end
    end

endmodule

// File: tb/tb_usehint_stream.sv
// Directed self-checking bench for usehint_stream (LANES=4, COEFF_W=24, W=64).
module tb_usehint_stream;
    localparam int LANES   = 4;
    localparam int COEFF_W = 24;
    localparam int W       = 64;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [2:0]               sec_lvl = 3'd2;
    logic [W-1:0]             di = '0;
    logic                     valid_i = 1'b0;
    logic                     ready_i;
    logic [LANES*COEFF_W-1:0] poly0_i = '0;
    logic [LANES*COEFF_W-1:0] poly1_i = '0;
    logic                     poly_valid_i = 1'b0;
    logic                     poly_ready_i;
    logic [LANES*COEFF_W-1:0] poly_o;
    logic                     poly_valid_o;
    logic                     poly_ready_o = 1'b0;
    logic                     done;
    logic                     hint_err;

    usehint_stream #(.LANES(LANES), .COEFF_W(COEFF_W), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sec_lvl(sec_lvl),
        .di(di), .valid_i(valid_i), .ready_i(ready_i),
        .poly0_i(poly0_i), .poly1_i(poly1_i), .poly_valid_i(poly_valid_i),
        .poly_ready_i(poly_ready_i), .poly_o(poly_o), .poly_valid_o(poly_valid_o),
        .poly_ready_o(poly_ready_o), .done(done), .hint_err(hint_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]         hb [0:127];
    logic [COEFF_W-1:0] r0_cfg [LANES];
    logic [COEFF_W-1:0] r1_cfg [LANES];
    logic [COEFF_W-1:0] cap [0:2047];
    int cap_n, done_cnt, pri_seen, timed_out, t_start, t_done;

    task automatic clear_hint();
        for (int i = 0; i < 128; i++) hb[i] = 8'd0;
    endtask

    task automatic set_lanes(input int r0, input int r1);
        for (int l = 0; l < LANES; l++) begin
            r0_cfg[l] = COEFF_W'(r0);
            r1_cfg[l] = COEFF_W'(r1);
        end
    endtask

    task automatic start_job(input logic [2:0] lvl);
        @(negedge clk);
        start = 1'b1;
        sec_lvl = lvl;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Stream n hint bytes; gaps inserts idle cycles with valid_i low between beats.
    task automatic send_hint(input int n, input bit gaps);
        int nb;
        int guard;
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                valid_i = 1'b0;
                repeat (3) @(negedge clk);
            end
            for (int j = 0; j < 8; j++) di[8*j +: 8] = hb[b*8 + j];
            valid_i = 1'b1;
            guard = 0;
            while (!ready_i && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    // Drive poly beats and capture accepted outputs until done (or max_beats captured).
    task automatic run_apply(input bit bp, input int max_beats);
        cap_n = 0; done_cnt = 0; pri_seen = 0; timed_out = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int l = 0; l < LANES; l++) begin
                poly0_i[l*COEFF_W +: COEFF_W] = r0_cfg[l];
                poly1_i[l*COEFF_W +: COEFF_W] = r1_cfg[l];
            end
            poly_valid_i = 1'b1;
            poly_ready_o = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (poly_ready_i) pri_seen = 1;
            if (poly_valid_o && poly_ready_o && cap_n < 512) begin
                for (int l = 0; l < LANES; l++) cap[cap_n*LANES + l] = poly_o[l*COEFF_W +: COEFF_W];
                cap_n++;
            end
            if (done) begin
                done_cnt++;
                t_done = cyc;
                timed_out = 0;
                break;
            end
            if (max_beats > 0 && cap_n >= max_beats) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        poly_valid_i = 1'b0;
        poly_ready_o = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({ready_i, poly_ready_i, poly_valid_o, done, hint_err} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {ready_i, poly_ready_i, poly_valid_o, done, hint_err});
            n_bad++;
        end
        n_vec++;
        if (poly_o !== '0) begin
            $display("FAIL reset_poly_o: got %h, required 0", poly_o);
            n_bad++;
        end
    endtask

    task automatic test_zero_hint();
        int bad;
        clear_hint();
        set_lanes(5, 7);
        start_job(3'd2);
        send_hint(84, 1'b0);
        run_apply(1'b0, 0);
        n_vec++;
        if (timed_out != 0 || done_cnt != 1) begin
            $display("FAIL zero_hint_done: timed_out=%0d done_cnt=%0d, required 0/1", timed_out, done_cnt);
            n_bad++;
        end
        n_vec++;
        if (cap_n != 256) begin
            $display("FAIL zero_hint_beats: got %0d, required 256", cap_n);
            n_bad++;
        end
        bad = 0;
        for (int i = 0; i < cap_n*LANES; i++) if (cap[i] !== 24'd7) bad++;
        n_vec++;
        if (bad != 0) begin
            $display("FAIL zero_hint_coeffs: %0d coefficients differ from 7, required 0", bad);
            n_bad++;
        end
        n_vec++;
        if (t_done - t_start != 348) begin
            $display("FAIL zero_hint_latency: got %0d, required 348", t_done - t_start);
            n_bad++;
        end
        n_vec++;
        if (hint_err !== 1'b0) begin
            $display("FAIL zero_hint_err: got %b, required 0", hint_err);
            n_bad++;
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({done, poly_valid_o, poly_ready_i} !== 3'b000 || poly_o !== '0) begin
            $display("FAIL zero_hint_after_done: done/valid/ready=%b poly_o=%h, required 000/0",
                     {done, poly_valid_o, poly_ready_i}, poly_o);
            n_bad++;
        end
    endtask

    task automatic test_wrap_up(input bit bp);
        int bad;
        clear_hint();
        hb[0] = 8'd0;
        for (int k = 0; k < 6; k++) hb[55 + k] = 8'd1;
        set_lanes(1, 15);
        start_job(3'd3);
        send_hint(61, bp);
        run_apply(bp, 0);
        n_vec++;
        if (timed_out != 0 || cap_n != 384) begin
            $display("FAIL lvl3_beats: timed_out=%0d beats=%0d, required 0/384", timed_out, cap_n);
            n_bad++;
        end
        n_vec++;
        if (cap[0] !== 24'd0) begin
            $display("FAIL lvl3_wrap_up: got %0d, required 0", cap[0]);
            n_bad++;
        end
        bad = 0;
        for (int i = 1; i < cap_n*LANES; i++) if (cap[i] !== 24'd15) bad++;
        n_vec++;
        if (bad != 0) begin
            $display("FAIL lvl3_others: %0d coefficients differ from 15, required 0", bad);
            n_bad++;
        end
        n_vec++;
        if (hint_err !== 1'b0) begin
            $display("FAIL lvl3_err: got %b, required 0", hint_err);
            n_bad++;
        end
    endtask

    task automatic test_wrap_down();
        int bad;
        clear_hint();
        hb[0] = 8'd255;
        hb[82] = 8'd1;
        set_lanes(0, 0);
        start_job(3'd5);
        send_hint(83, 1'b0);
        run_apply(1'b0, 0);
        n_vec++;
        if (timed_out != 0 || cap_n != 512) begin
            $display("FAIL lvl5_beats: timed_out=%0d beats=%0d, required 0/512", timed_out, cap_n);
            n_bad++;
        end
        n_vec++;
        if (cap[2047] !== 24'd15) begin
            $display("FAIL lvl5_wrap_down: got %0d, required 15", cap[2047]);
            n_bad++;
        end
        bad = 0;
        for (int i = 0; i < 2047; i++) if (cap[i] !== 24'd0) bad++;
        n_vec++;
        if (bad != 0) begin
            $display("FAIL lvl5_others: %0d coefficients differ from 0, required 0", bad);
            n_bad++;
        end
    endtask

    // Indices 0..3 in poly 0; lanes 0,1 sit at r0=gamma2, lanes 2,3 at gamma2+1.
    task automatic load_gamma_job();
        clear_hint();
        for (int i = 0; i < 4; i++) hb[i] = 8'(i);
        for (int k = 0; k < 4; k++) hb[80 + k] = 8'd4;
        r0_cfg[0] = 24'd95232; r0_cfg[1] = 24'd95232;
        r0_cfg[2] = 24'd95233; r0_cfg[3] = 24'd95233;
        for (int l = 0; l < LANES; l++) r1_cfg[l] = 24'd43;
    endtask

    task automatic test_gamma_boundary();
        int bad;
        load_gamma_job();
        start_job(3'd2);
        send_hint(84, 1'b0);
        run_apply(1'b0, 0);
        n_vec++;
        if (timed_out != 0 || cap_n != 256) begin
            $display("FAIL gamma_beats: timed_out=%0d beats=%0d, required 0/256", timed_out, cap_n);
            n_bad++;
        end
        n_vec++;
        if (cap[0] !== 24'd0 || cap[1] !== 24'd0) begin
            $display("FAIL gamma_at_g2: got %0d %0d, required 0 0", cap[0], cap[1]);
            n_bad++;
        end
        n_vec++;
        if (cap[2] !== 24'd42 || cap[3] !== 24'd42) begin
            $display("FAIL gamma_above_g2: got %0d %0d, required 42 42", cap[2], cap[3]);
            n_bad++;
        end
        bad = 0;
        for (int i = 4; i < cap_n*LANES; i++) if (cap[i] !== 24'd43) bad++;
        n_vec++;
        if (bad != 0) begin
            $display("FAIL gamma_others: %0d coefficients differ from 43, required 0", bad);
            n_bad++;
        end
    endtask

    task automatic test_dup_index();
        int bad;
        clear_hint();
        hb[0] = 8'd5; hb[1] = 8'd5;
        for (int k = 0; k < 4; k++) hb[80 + k] = 8'd2;
        set_lanes(5, 7);
        start_job(3'd2);
        send_hint(84, 1'b0);
        run_apply(1'b0, 0);
        n_vec++;
        if (timed_out != 0 || done_cnt != 1) begin
            $display("FAIL dup_done: timed_out=%0d done_cnt=%0d, required 0/1", timed_out, done_cnt);
            n_bad++;
        end
`ifdef USEHINT_CHECK_EN
        n_vec++;
        if (hint_err !== 1'b1) begin
            $display("FAIL dup_err: got %b, required 1", hint_err);
            n_bad++;
        end
        n_vec++;
        if (pri_seen != 0 || cap_n != 0) begin
            $display("FAIL dup_no_apply: ready_seen=%0d beats=%0d, required 0/0", pri_seen, cap_n);
            n_bad++;
        end
        @(negedge clk);
        n_vec++;
        if (hint_err !== 1'b1 || done !== 1'b0) begin
            $display("FAIL dup_err_held: err=%b done=%b, required 1/0", hint_err, done);
            n_bad++;
        end
`else
        n_vec++;
        if (cap_n != 256 || cap[5] !== 24'd8) begin
            $display("FAIL dup_apply: beats=%0d coeff5=%0d, required 256/8", cap_n, cap[5]);
            n_bad++;
        end
        bad = 0;
        for (int i = 0; i < cap_n*LANES; i++) if (i != 5 && cap[i] !== 24'd7) bad++;
        n_vec++;
        if (bad != 0 || hint_err !== 1'b0) begin
            $display("FAIL dup_others: %0d bad, err=%b, required 0/0", bad, hint_err);
            n_bad++;
        end
`endif
    endtask

    task automatic test_pad_byte();
        clear_hint();
        hb[0] = 8'd3;
        hb[10] = 8'd9;
        for (int k = 0; k < 4; k++) hb[80 + k] = 8'd1;
        set_lanes(5, 7);
        start_job(3'd2);
        n_vec++;
        if (hint_err !== 1'b0) begin
            $display("FAIL pad_err_cleared: got %b, required 0", hint_err);
            n_bad++;
        end
        send_hint(84, 1'b0);
        run_apply(1'b0, 0);
`ifdef USEHINT_CHECK_EN
        n_vec++;
        if (hint_err !== 1'b1 || done_cnt != 1 || pri_seen != 0) begin
            $display("FAIL pad_reject: err=%b done=%0d ready_seen=%0d, required 1/1/0",
                     hint_err, done_cnt, pri_seen);
            n_bad++;
        end
`else
        n_vec++;
        if (cap_n != 256 || cap[3] !== 24'd8 || cap[10] !== 24'd7) begin
            $display("FAIL pad_apply: beats=%0d c3=%0d c10=%0d, required 256/8/7", cap_n, cap[3], cap[10]);
            n_bad++;
        end
`endif
    endtask

    task automatic test_backpressure_reset();
        int bad;
        load_gamma_job();
        start_job(3'd2);
        send_hint(84, 1'b1);
        run_apply(1'b1, 20);
        n_vec++;
        if (timed_out != 0 || cap_n != 20) begin
            $display("FAIL bp_partial_beats: timed_out=%0d beats=%0d, required 0/20", timed_out, cap_n);
            n_bad++;
        end
        bad = 0;
        for (int i = 0; i < cap_n*LANES; i++)
            if (cap[i] !== ((i < 2) ? 24'd0 : (i < 4) ? 24'd42 : 24'd43)) bad++;
        n_vec++;
        if (bad != 0) begin
            $display("FAIL bp_partial_coeffs: %0d bad, required 0", bad);
            n_bad++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ready_i, poly_ready_i, poly_valid_o, done, hint_err} !== 5'b0 || poly_o !== '0) begin
            $display("FAIL midjob_reset: ctrl=%b poly_o=%h, required 00000/0",
                     {ready_i, poly_ready_i, poly_valid_o, done, hint_err}, poly_o);
            n_bad++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        n_vec++;
        if (done_cnt != 0 || ready_i !== 1'b0) begin
            $display("FAIL reset_no_done: done_cnt=%0d ready_i=%b, required 0/0", done_cnt, ready_i);
            n_bad++;
        end
        test_wrap_up(1'b1);
    endtask

    initial begin
        clear_hint();
        set_lanes(0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_zero_hint();
        test_wrap_up(1'b0);
        test_wrap_down();
        test_gamma_boundary();
        test_dup_index();
        test_pad_byte();
        test_backpressure_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
